// File: rtl/buscaminas_pkg.sv
// Shared types and helpers for the minesweeper neighbour-count scanner.
package buscaminas_pkg;

  localparam int CELL_W_DEF    = 4;
  localparam int MINE_CODE_DEF = 15;

  typedef logic [CELL_W_DEF-1:0] cell_t;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
  typedef logic [7:0] nbr_flags_t;

  function automatic logic [3:0] popcount8(input nbr_flags_t f);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, f[i]};
    return n;
  endfunction

endpackage

// File: rtl/contar_bombas_fila.sv
// Combinational neighbour counter for one board row, given the rows above and below.
module contar_bombas_fila
  import buscaminas_pkg::*;
#(
  parameter int COLS      = 8,
  parameter int CELL_W    = CELL_W_DEF,
  parameter int MINE_CODE = MINE_CODE_DEF
) (
  input  logic [COLS-1:0][CELL_W-1:0]  row_up_i,
  input  logic [COLS-1:0][CELL_W-1:0]  row_mid_i,
  input  logic [COLS-1:0][CELL_W-1:0]  row_dn_i,
  input  logic                         up_valid_i,
  input  logic                         dn_valid_i,
  input  logic                         diag_en_i,
  output logic [COLS-1:0][CELL_W-1:0]  row_o,
  output logic [$clog2(COLS+1)-1:0]    mines_o
);

  localparam int RM_W = $clog2(COLS + 1);
  localparam logic [CELL_W-1:0] MINE = CELL_W'(MINE_CODE);

  // Mine flags padded with a zero column on each side so edges need no special case.
  logic [COLS+1:0] up_p, mid_p, dn_p;
  nbr_flags_t      flags;
  logic [3:0]      cnt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    up_p  = '0;
    mid_p = '0;
    dn_p  = '0;
    for (int c = 0; c < COLS; c++) begin
      up_p[c+1]  = up_valid_i && (row_up_i[c] == MINE);
      mid_p[c+1] = (row_mid_i[c] == MINE);
      dn_p[c+1]  = dn_valid_i && (row_dn_i[c] == MINE);
    end
  end

  always_comb begin
    flags   = '0;
    cnt     = '0;
    row_o   = '0;
    mines_o = '0;
    for (int c = 0; c < COLS; c++) begin
      flags = {diag_en_i & up_p[c], up_p[c+1], diag_en_i & up_p[c+2],
               mid_p[c],                        mid_p[c+2],
               diag_en_i & dn_p[c], dn_p[c+1], diag_en_i & dn_p[c+2]};
      cnt      = popcount8(flags);
      row_o[c] = mid_p[c+1] ? MINE : CELL_W'(cnt);
      mines_o  = mines_o + RM_W'(mid_p[c+1]);
    end
  end

endmodule

// File: rtl/contar_bombas_scan.sv
// Sequential minesweeper board scanner: snapshots a board on start, resolves one row per clock.
module contar_bombas_scan
  import buscaminas_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int CELL_W    = CELL_W_DEF,
  parameter int MINE_CODE = MINE_CODE_DEF
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                diag_en,
  input  logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] board_in,
  output logic                                busy,
  output logic                                done,
  output logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] board_out,
  output logic [$clog2(ROWS*COLS+1)-1:0]      mine_total
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int TOT_W = $clog2(ROWS * COLS + 1);
  localparam int RM_W  = $clog2(COLS + 1);

  typedef logic [COLS-1:0][CELL_W-1:0]            row_t;
  typedef logic [ROWS-1:0][COLS-1:0][CELL_W-1:0]  board_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [TOT_W-1:0] acc_q, acc_d, total_q, total_d;
  logic             busy_q, busy_d, done_q, done_d;
  board_t           board_q, board_d, snap_q;
  logic             diag_q;

  row_t             row_up, row_mid, row_dn, row_res;
  logic [RM_W-1:0]  row_mines;
  logic             accept, last_row, up_valid, dn_valid;

  assign accept   = (state_q == IDLE) && start;
  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign up_valid = (row_q != '0);
  assign dn_valid = !last_row;

  // NOTE: the snapshot is plain data storage qualified by the FSM, so it carries no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      snap_q <= board_in;
      diag_q <= diag_en;
    end
  end

  always_comb begin
    row_up  = '0;
    row_dn  = '0;
    row_mid = snap_q[row_q];
    if (up_valid) row_up = snap_q[row_q - 1'b1];
    if (dn_valid) row_dn = snap_q[row_q + 1'b1];
  end

  contar_bombas_fila #(
    .COLS      (COLS),
    .CELL_W    (CELL_W),
    .MINE_CODE (MINE_CODE)
  ) u_fila (
    .row_up_i   (row_up),
    .row_mid_i  (row_mid),
    .row_dn_i   (row_dn),
    .up_valid_i (up_valid),
    .dn_valid_i (dn_valid),
    .diag_en_i  (diag_q),
    .row_o      (row_res),
    .mines_o    (row_mines)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    board_d = board_q;
    total_d = total_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          busy_d  = 1'b1;
          row_d   = '0;
          acc_d   = '0;
        end
      end
      SCAN: begin
        board_d[row_q] = row_res;
        acc_d          = acc_q + TOT_W'(row_mines);
        row_d          = row_q + 1'b1;
        if (last_row) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          total_d = acc_d;
          row_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      board_q <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      board_q <= board_d;
      total_q <= total_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign board_out  = board_q;
  assign mine_total = total_q;

endmodule

// File: tb/tb_contar_bombas_scan.sv
// Directed bench for contar_bombas_scan: 8x8 vector table plus 5x12 back-to-back and reset corner cases.
module tb_contar_bombas_scan;

  typedef logic [7:0][7:0][3:0]  board_a_t;
  typedef logic [4:0][11:0][3:0] board_b_t;

  typedef struct {
    string    name;
    board_a_t board;
    logic     diag;
    board_a_t exp;
    int       total;
  } vec_t;

  logic     clock = 1'b0;
  logic     reset = 1'b1;
  logic     start_a = 1'b0, diag_a = 1'b0;
  board_a_t board_in_a = '0;
  logic     busy_a, done_a;
  board_a_t board_out_a;
  logic [6:0] total_a;

  logic     start_b = 1'b0, diag_b = 1'b0;
  board_b_t board_in_b = '0;
  logic     busy_b, done_b;
  board_b_t board_out_b;
  logic [5:0] total_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  contar_bombas_scan dut_a (
    .clock      (clock),
    .reset      (reset),
    .start      (start_a),
    .diag_en    (diag_a),
    .board_in   (board_in_a),
    .busy       (busy_a),
    .done       (done_a),
    .board_out  (board_out_a),
    .mine_total (total_a)
  );

  contar_bombas_scan #(.ROWS(5), .COLS(12)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .start      (start_b),
    .diag_en    (diag_b),
    .board_in   (board_in_b),
    .busy       (busy_b),
    .done       (done_b),
    .board_out  (board_out_b),
    .mine_total (total_b)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Pulse start for one cycle, then watch busy/done for 20 cycles; optionally disturb inputs during the scan.
  task automatic run_a(input board_a_t b, input logic d, input bit disturb, input board_a_t alt,
                       output int lat, output int busy_cnt, output int done_cnt);
    @(negedge clock);
    board_in_a = b;
    diag_a     = d;
    start_a    = 1'b1;
    @(negedge clock);
    start_a  = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
      if (disturb && k < 8) begin
        board_in_a = (k % 2 == 1) ? ~b : alt;
        diag_a     = ~diag_a;
        start_a    = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  vec_t     vecs[5];
  board_a_t single, ring, edge_bd, e;
  board_b_t corner, corner_exp;
  int lat, lat2, bc, dc;

  initial begin
    single = '0; single[0][0] = 4'd15;
    ring = '0;
    ring[2][2] = 4'd15; ring[2][3] = 4'd15; ring[2][4] = 4'd15; ring[3][2] = 4'd15;
    ring[3][4] = 4'd15; ring[4][2] = 4'd15; ring[4][3] = 4'd15; ring[4][4] = 4'd15;
    edge_bd = '0;
    edge_bd[0][7] = 4'd15; edge_bd[7][7] = 4'd15; edge_bd[7][0] = 4'd14; edge_bd[3][0] = 4'd8;

    e = single; e[0][1] = 4'd1; e[1][0] = 4'd1; e[1][1] = 4'd1;
    vecs[0].name = "single_diag"; vecs[0].board = single; vecs[0].diag = 1'b1; vecs[0].exp = e; vecs[0].total = 1;
    e = single; e[0][1] = 4'd1; e[1][0] = 4'd1;
    vecs[1].name = "single_orth"; vecs[1].board = single; vecs[1].diag = 1'b0; vecs[1].exp = e; vecs[1].total = 1;

    e = ring; e[3][3] = 4'd8;
    e[1][1] = 4'd1; e[1][2] = 4'd2; e[1][3] = 4'd3; e[1][4] = 4'd2; e[1][5] = 4'd1;
    e[2][1] = 4'd2; e[2][5] = 4'd2; e[3][1] = 4'd3; e[3][5] = 4'd3; e[4][1] = 4'd2; e[4][5] = 4'd2;
    e[5][1] = 4'd1; e[5][2] = 4'd2; e[5][3] = 4'd3; e[5][4] = 4'd2; e[5][5] = 4'd1;
    vecs[2].name = "ring_diag"; vecs[2].board = ring; vecs[2].diag = 1'b1; vecs[2].exp = e; vecs[2].total = 8;

    e = ring; e[3][3] = 4'd4;
    e[1][2] = 4'd1; e[1][3] = 4'd1; e[1][4] = 4'd1;
    e[2][1] = 4'd1; e[2][5] = 4'd1; e[3][1] = 4'd1; e[3][5] = 4'd1; e[4][1] = 4'd1; e[4][5] = 4'd1;
    e[5][2] = 4'd1; e[5][3] = 4'd1; e[5][4] = 4'd1;
    vecs[3].name = "ring_orth"; vecs[3].board = ring; vecs[3].diag = 1'b0; vecs[3].exp = e; vecs[3].total = 8;

    // Non-mine codes 14 and 8 must be recounted as 0; no wrap from column 0 to column 7.
    e = '0; e[0][7] = 4'd15; e[7][7] = 4'd15;
    e[0][6] = 4'd1; e[1][6] = 4'd1; e[1][7] = 4'd1; e[7][6] = 4'd1; e[6][6] = 4'd1; e[6][7] = 4'd1;
    vecs[4].name = "edges_diag"; vecs[4].board = edge_bd; vecs[4].diag = 1'b1; vecs[4].exp = e; vecs[4].total = 2;

    corner = '0; corner[4][11] = 4'd15;
    corner_exp = corner; corner_exp[4][10] = 4'd1; corner_exp[3][11] = 4'd1;

    #12;
    check("reset busy_a", 256'(busy_a), 256'(0));
    check("reset done_a", 256'(done_a), 256'(0));
    check("reset board_a", 256'(board_out_a), 256'(0));
    check("reset total_a", 256'(total_a), 256'(0));
    check("reset busy_b", 256'(busy_b), 256'(0));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_a(vecs[i].board, vecs[i].diag, 1'b0, '0, lat, bc, dc);
      check({vecs[i].name, " latency"}, 256'(lat), 256'(8));
      check({vecs[i].name, " busy_cycles"}, 256'(bc), 256'(8));
      check({vecs[i].name, " done_pulses"}, 256'(dc), 256'(1));
      check({vecs[i].name, " board"}, 256'(board_out_a), 256'(vecs[i].exp));
      check({vecs[i].name, " total"}, 256'(total_a), 256'(vecs[i].total));
    end

    // Inputs and start toggled throughout the scan: result must follow the E0 snapshot.
    run_a(single, 1'b1, 1'b1, ring, lat, bc, dc);
    check("disturb latency", 256'(lat), 256'(8));
    check("disturb done_pulses", 256'(dc), 256'(1));
    check("disturb board", 256'(board_out_a), 256'(vecs[0].exp));
    check("disturb total", 256'(total_a), 256'(1));

    // Reset asserted just after E2 of a ring scan clears everything immediately.
    @(negedge clock);
    board_in_a = ring; diag_a = 1'b1; start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midreset busy", 256'(busy_a), 256'(0));
    check("midreset done", 256'(done_a), 256'(0));
    check("midreset board", 256'(board_out_a), 256'(0));
    check("midreset total", 256'(total_a), 256'(0));
    @(negedge clock);
    reset = 1'b0;
    run_a(single, 1'b0, 1'b0, '0, lat, bc, dc);
    check("after_reset latency", 256'(lat), 256'(8));
    check("after_reset board", 256'(board_out_a), 256'(vecs[1].exp));

    // 5x12 all-mine board, then a new start held in the done cycle.
    @(negedge clock);
    board_in_b = '1; diag_b = 1'b1; start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    lat = -1; lat2 = -1; bc = 0; dc = 0;
    for (int k = 0; k < 25; k++) begin
      start_b = 1'b0;
      if (busy_b && lat < 0) bc++;
      if (done_b) begin
        dc++;
        if (lat < 0) begin
          lat = k;
          check("allmine board", 256'(board_out_b), 256'(board_b_t'('1)));
          check("allmine total", 256'(total_b), 256'(60));
          check("allmine busy_in_done", 256'(busy_b), 256'(0));
          board_in_b = corner; diag_b = 1'b0; start_b = 1'b1;
        end else if (lat2 < 0) begin
          lat2 = k;
        end
      end
      @(negedge clock);
    end
    check("allmine latency", 256'(lat), 256'(5));
    check("allmine busy_cycles", 256'(bc), 256'(5));
    check("b2b latency", 256'(lat2), 256'(11));
    check("b2b done_pulses", 256'(dc), 256'(2));
    check("b2b board", 256'(board_out_b), 256'(corner_exp));
    check("b2b total", 256'(total_b), 256'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
